stopwatch_ctrl: RTL

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button-driven stopwatch controller that synchronizes and debounces two
// raw push-buttons, runs the IDLE/RUN/PAUSE/LAP FSM, and divides clk into tick pulses.
module stopwatch_ctrl #(
  parameter int TICK_DIV        = 10_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_start_stop,
  input  logic       btn_lap_reset,
  output logic       tick,
  output logic       clear,
  output logic       running,
  output logic       lap_hold,
  output logic [1:0] state
);
  localparam int DW = $clog2(TICK_DIV);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DMAX = DW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} state_t;

  state_t          r_state, w_nxt;
  logic [1:0]      r_s1, r_s2, r_acc, r_acc_d;
  logic [CW-1:0]   r_cnt [2];
  logic [DW-1:0]   r_div, w_div_nxt;
  logic            r_tick, r_clear, r_running, r_lap_hold;
  logic [1:0]      w_press;
  logic            w_ss, w_lr, w_clr, w_go, w_wrap;

  // bit 0 = start/stop, bit 1 = lap/reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_acc   <= '0;
      r_acc_d <= '0;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_s1    <= {btn_lap_reset, btn_start_stop};
      r_s2    <= r_s1;
      r_acc_d <= r_acc;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_acc[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == CMAX) begin
          r_acc[i] <= r_s2[i];
          r_cnt[i] <= '0;
        end else r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  // start/stop wins when both buttons fire in the same cycle
  assign w_press = r_acc & ~r_acc_d;
  assign w_ss    = w_press[0];
  assign w_lr    = w_press[1] & ~w_press[0];

  always_comb begin
    w_nxt = r_state;
    w_clr = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ss) w_nxt = RUN;
        else if (w_lr) w_clr = 1'b1;
      end
      RUN:   w_nxt = w_ss ? PAUSE : w_lr ? LAP : RUN;
      LAP:   w_nxt = w_ss ? PAUSE : w_lr ? RUN : LAP;
      PAUSE: begin
        if (w_ss) w_nxt = RUN;
        else if (w_lr) begin
          w_nxt = IDLE;
          w_clr = 1'b1;
        end
      end
      default: w_nxt = IDLE;
    endcase
    // divider advances only while staying in a running state, so pausing keeps the phase
    w_go      = r_state[0] & w_nxt[0];
    w_wrap    = r_div == DMAX;
    w_div_nxt = (w_clr || (r_state == IDLE && w_nxt == RUN)) ? '0 :
                !w_go ? r_div : w_wrap ? '0 : r_div + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_div      <= '0;
      r_tick     <= 1'b0;
      r_clear    <= 1'b0;
      r_running  <= 1'b0;
      r_lap_hold <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_div      <= w_div_nxt;
      r_tick     <= w_go & w_wrap;
      r_clear    <= w_clr;
      r_running  <= w_nxt[0];
      r_lap_hold <= w_nxt == LAP;
    end
  end

  assign tick     = r_tick;
  assign clear    = r_clear;
  assign running  = r_running;
  assign lap_hold = r_lap_hold;
  assign state    = r_state;
endmodule
